// File: rtl/ahb_interconnect.sv
// ahb_interconnect: 2-master/2-slave AHB shared bus with round-robin arbiter, MSB address decoder and data-phase response mux.
module ahb_interconnect #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          m_hbusreq,
  input  logic [3:0]          m_htrans,
  input  logic [2*ADDR_W-1:0] m_haddr,
  input  logic [1:0]          m_hwrite,
  input  logic [5:0]          m_hsize,
  input  logic [2*DATA_W-1:0] m_hwdata,
  output logic [1:0]          m_hgrant,
  output logic                hmaster,
  output logic [DATA_W-1:0]   hrdata,
  output logic                hready,
  output logic [1:0]          hresp,
  output logic [ADDR_W-1:0]   haddr,
  output logic [1:0]          htrans,
  output logic                hwrite,
  output logic [2:0]          hsize,
  output logic [DATA_W-1:0]   hwdata,
  output logic [1:0]          hsel,
  input  logic [2*DATA_W-1:0] s_hrdata,
  input  logic [1:0]          s_hready,
  input  logic [3:0]          s_hresp
);
  logic owner_q, owner_d;
  logic dp_valid_q, dp_valid_d;
  logic dp_slave_q, dp_slave_d;
  logic dp_master_q, dp_master_d;

  assign hmaster  = owner_q;
  assign m_hgrant = owner_q ? 2'b10 : 2'b01;
  assign haddr    = hmaster ? m_haddr[2*ADDR_W-1:ADDR_W] : m_haddr[ADDR_W-1:0];
  assign htrans   = hmaster ? m_htrans[3:2] : m_htrans[1:0];
  assign hwrite   = hmaster ? m_hwrite[1] : m_hwrite[0];
  assign hsize    = hmaster ? m_hsize[5:3] : m_hsize[2:0];
  assign hsel     = haddr[ADDR_W-1] ? 2'b10 : 2'b01;
  assign hwdata   = dp_master_q ? m_hwdata[2*DATA_W-1:DATA_W] : m_hwdata[DATA_W-1:0];
  // An idle data phase answers OKAY with zero wait states on behalf of no slave.
  assign hready   = dp_valid_q ? s_hready[dp_slave_q] : 1'b1;
  assign hresp    = dp_valid_q ? (dp_slave_q ? s_hresp[3:2] : s_hresp[1:0]) : 2'b00;
  assign hrdata   = dp_valid_q ? (dp_slave_q ? s_hrdata[2*DATA_W-1:DATA_W] : s_hrdata[DATA_W-1:0]) : '0;

  always_comb begin
    owner_d     = (hready && m_hbusreq[~owner_q]) ? ~owner_q : owner_q;
    dp_valid_d  = hready ? htrans[1] : dp_valid_q;
    dp_slave_d  = hready ? haddr[ADDR_W-1] : dp_slave_q;
    dp_master_d = hready ? hmaster : dp_master_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      owner_q     <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_slave_q  <= 1'b0;
      dp_master_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      dp_valid_q  <= dp_valid_d;
      dp_slave_q  <= dp_slave_d;
      dp_master_q <= dp_master_d;
    end
  end
endmodule

// File: tb/tb_ahb_interconnect.sv
// tb_ahb_interconnect: directed stimulus pushes expectations into a scoreboard queue; a negedge monitor pops and compares them.
module tb_ahb_interconnect;
  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  m_hbusreq;
  logic [3:0]  m_htrans;
  logic [63:0] m_haddr;
  logic [1:0]  m_hwrite;
  logic [5:0]  m_hsize;
  logic [63:0] m_hwdata;
  logic [1:0]  m_hgrant;
  logic        hmaster;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [1:0]  hsel;
  logic [63:0] s_hrdata;
  logic [1:0]  s_hready;
  logic [3:0]  s_hresp;

  localparam int GRANT = 0, HMASTER = 1, HREADY = 2, HRESP = 3, HRDATA = 4, HADDR = 5, HSEL = 6, HWDATA = 7;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  ahb_interconnect dut (
    .clk(clk), .rstn(rstn), .m_hbusreq(m_hbusreq), .m_htrans(m_htrans), .m_haddr(m_haddr),
    .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hwdata(m_hwdata), .m_hgrant(m_hgrant),
    .hmaster(hmaster), .hrdata(hrdata), .hready(hready), .hresp(hresp), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hsel(hsel),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pick(int sel);
    case (sel)
      GRANT:   return {30'd0, m_hgrant};
      HMASTER: return {31'd0, hmaster};
      HREADY:  return {31'd0, hready};
      HRESP:   return {30'd0, hresp};
      HRDATA:  return hrdata;
      HADDR:   return haddr;
      HSEL:    return {30'd0, hsel};
      default: return hwdata;
    endcase
  endfunction

  task automatic exp_push(input string n, input int s, input logic [31:0] e);
    sb.push_back('{n, s, e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m1(input logic [1:0] t, input logic [31:0] a, input logic w);
    m_htrans[3:2] = t;
    m_haddr[63:32] = a;
    m_hwrite[1] = w;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = pick(e.sel);
        n_checks++;
        if (got === e.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, got, e.exp, $time);
      end
    end
  end

  initial begin
    rstn = 1'b0; m_hbusreq = 2'b00; m_htrans = '0; m_haddr = '0; m_hwrite = '0;
    m_hsize = 6'b010_010; m_hwdata = {32'hDEAD_BEEF, 32'h0000_CAFE};
    s_hrdata = {32'hA5A5_A5A5, 32'h1111_1111}; s_hready = 2'b11; s_hresp = 4'b0000;
    step();
    // C0: reset state
    rstn = 1'b1; m_hbusreq = 2'b10;
    exp_push("rst_grant", GRANT, 32'h1); exp_push("rst_hmaster", HMASTER, 32'h0);
    exp_push("rst_hready", HREADY, 32'h1); exp_push("rst_hresp", HRESP, 32'h0);
    exp_push("rst_hrdata", HRDATA, 32'h0);
    step();
    // C1: master1 granted, issues read to slave0
    m_hbusreq = 2'b00; drive_m1(NONSEQ, 32'h0000_0010, 1'b0);
    exp_push("grant_m1", GRANT, 32'h2); exp_push("hmaster_m1", HMASTER, 32'h1);
    exp_push("dec_s0", HSEL, 32'h1); exp_push("haddr_s0", HADDR, 32'h0000_0010);
    step();
    // C2: parked grant, read to slave1, slave0 data phase
    drive_m1(NONSEQ, 32'h8000_0010, 1'b0);
    exp_push("grant_park", GRANT, 32'h2); exp_push("dec_s1", HSEL, 32'h2);
    exp_push("rdata_s0", HRDATA, 32'h1111_1111); exp_push("hready_s0", HREADY, 32'h1);
    step();
    // C3: slave1 data phase with ERROR passthrough, master1 write address
    drive_m1(NONSEQ, 32'h8000_0000, 1'b1); s_hresp = 4'b0100;
    exp_push("rdata_s1", HRDATA, 32'hA5A5_A5A5); exp_push("hready_s1", HREADY, 32'h1);
    exp_push("hresp_err", HRESP, 32'h1);
    step();
    // C4: write data phase
    drive_m1(IDLE, 32'h0, 1'b0); s_hresp = 4'b0000; m_hwdata[63:32] = 32'h1234_5678;
    m_hbusreq = 2'b11;
    exp_push("hwdata_m1", HWDATA, 32'h1234_5678);
    step();
    // C5: ownership moves to master0, master0 reads slave0
    m_htrans[1:0] = NONSEQ; m_haddr[31:0] = 32'h0000_0040;
    exp_push("rr_grant_m0", GRANT, 32'h1); exp_push("rr_hmaster_m0", HMASTER, 32'h0);
    exp_push("haddr_m0", HADDR, 32'h0000_0040);
    step();
    // C6: slave0 inserts wait state
    m_htrans[1:0] = IDLE; drive_m1(NONSEQ, 32'h8000_0080, 1'b0); s_hready = 2'b10;
    exp_push("wait1_hready", HREADY, 32'h0); exp_push("wait1_grant", GRANT, 32'h2);
    exp_push("wait1_haddr", HADDR, 32'h8000_0080);
    step();
    // C7: still waiting, everything frozen
    exp_push("wait2_hready", HREADY, 32'h0); exp_push("wait2_grant", GRANT, 32'h2);
    exp_push("wait2_hmaster", HMASTER, 32'h1); exp_push("wait2_haddr", HADDR, 32'h8000_0080);
    step();
    // C8: wait released; grant did not move, data phase still slave0
    s_hready = 2'b11;
    exp_push("rel_hready", HREADY, 32'h1); exp_push("rel_grant", GRANT, 32'h2);
    exp_push("rel_rdata_s0", HRDATA, 32'h1111_1111);
    step();
    // C9: alternation resumes
    drive_m1(IDLE, 32'h0, 1'b0);
    exp_push("alt_grant_m0", GRANT, 32'h1); exp_push("alt_hmaster_m0", HMASTER, 32'h0);
    exp_push("alt_rdata_s1", HRDATA, 32'hA5A5_A5A5);
    step();
    // C10: back to master1, idle data phase; reset asserted mid-transfer
    drive_m1(NONSEQ, 32'h8000_0000, 1'b0); rstn = 1'b0;
    exp_push("alt_grant_m1", GRANT, 32'h2); exp_push("idle_hrdata", HRDATA, 32'h0);
    step();
    // C11: reset dropped the pending transfer
    rstn = 1'b1; m_hbusreq = 2'b00;
    exp_push("mid_rst_grant", GRANT, 32'h1); exp_push("mid_rst_hmaster", HMASTER, 32'h0);
    exp_push("mid_rst_hrdata", HRDATA, 32'h0); exp_push("mid_rst_hready", HREADY, 32'h1);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: simulation time exceeded, expected completion");
    $fatal(1);
  end
endmodule
